edabk_tx_arbiter: RTL and testbench

- Schedules one shared UART transmitter among NUM_REQ requesters.
- Each requester uses a valid/ready handshake. Requesters are served in round-robin order, one frame at a time.
- Drives the transmitter controller's start pulse and the parallel data word. Holds the grant until the transmitter reports finish.
- Sits between the client logic and the transmitter datapath, in the bclk domain.

---
 rtl/edabk_tx_arb_pkg.sv | 23 ++
 rtl/edabk_rr_arbiter.sv | 30 +++
 rtl/edabk_tx_arbiter.sv | 152 +++++++++++++++
 tb/tb_edabk_tx_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/edabk_tx_arb_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
// Frame width comes from CFG_DATA_WIDTH (defaults to 8 when not supplied).
// The optional WAIT_FIN watchdog is enabled by EDABK_TX_ARB_TIMEOUT_EN.

`ifndef CFG_DATA_WIDTH
`define CFG_DATA_WIDTH 8
`endif

package edabk_tx_arb_pkg;

    // Frame scheduling states
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT    = 2'd1,
        WAIT_FIN = 2'd2,
        RELEASE  = 2'd3
    } arb_state_t;

    localparam int DEFAULT_NUM_REQ        = 4;
    localparam int DEFAULT_TIMEOUT_CYCLES = 4096;
    localparam int DEFAULT_DATA_WIDTH     = `CFG_DATA_WIDTH;

endpackage

// File: rtl/edabk_rr_arbiter.sv
// Combinational round-robin pick: first set request bit scanning upward
// from rr_ptr and wrapping modulo NUM_REQ. Shared with the receiver side.

module edabk_rr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int IDX_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]   req,
    input  logic [IDX_WIDTH-1:0] rr_ptr,
    output logic [IDX_WIDTH-1:0] winner,
    output logic                 any_valid
);

    logic [IDX_WIDTH-1:0] idx;

    // Walk the requesters starting at rr_ptr; the first set bit wins
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        idx       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = IDX_WIDTH'((int'(rr_ptr) + i) % NUM_REQ);
            if (!any_valid && req[idx]) begin
                any_valid = 1'b1;
                winner    = idx;
            end
        end
    end

endmodule

// File: rtl/edabk_tx_arbiter.sv
// Round-robin scheduler for one shared UART transmitter.
// Serves NUM_REQ valid/ready requesters one frame at a time, issues the
// transmitter start pulse and holds the grant until tx_finish.
// Optional WAIT_FIN watchdog: define EDABK_TX_ARB_TIMEOUT_EN.

`ifndef CFG_DATA_WIDTH
`define CFG_DATA_WIDTH 8
`endif

module edabk_tx_arbiter
    import edabk_tx_arb_pkg::*;
#(
    parameter int NUM_REQ        = DEFAULT_NUM_REQ,
    parameter int DATA_WIDTH     = `CFG_DATA_WIDTH,
    parameter int IDX_WIDTH      = $clog2(NUM_REQ),
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                          bclk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          tx_start,
    output logic [DATA_WIDTH-1:0]         tx_data,
    input  logic                          tx_finish,
    output logic [IDX_WIDTH-1:0]          grant_id,
    output logic                          busy,
    output logic                          tx_timeout
);

    arb_state_t state, state_d;

    logic [IDX_WIDTH-1:0]  rr_ptr, rr_ptr_d;
    logic [IDX_WIDTH-1:0]  grant_id_d;
    logic [IDX_WIDTH-1:0]  winner;
    logic                  any_valid;
    logic [DATA_WIDTH-1:0] tx_data_d;
    logic [NUM_REQ-1:0]    req_ready_d;
    logic                  tx_start_d;
    logic                  busy_d;
    logic [DATA_WIDTH-1:0] req_words [NUM_REQ];

`ifdef EDABK_TX_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] wd_cnt, wd_cnt_d;
    logic             tx_timeout_d;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign tx_timeout         = 1'b0;
`endif

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign req_words[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    edabk_rr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_pick (
        .req       (req_valid),
        .rr_ptr    (rr_ptr),
        .winner    (winner),
        .any_valid (any_valid)
    );

    // Next-state and next-output logic; every output is registered below
    always_comb begin
        state_d     = state;
        rr_ptr_d    = rr_ptr;
        tx_data_d   = tx_data;
        grant_id_d  = grant_id;
        tx_start_d  = 1'b0;
        req_ready_d = '0;
`ifdef EDABK_TX_ARB_TIMEOUT_EN
        wd_cnt_d     = wd_cnt;
        tx_timeout_d = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (any_valid) begin
                    state_d     = GRANT;
                    tx_data_d   = req_words[winner];
                    grant_id_d  = winner;
                    tx_start_d  = 1'b1;
                    req_ready_d = NUM_REQ'(1) << winner;
                end
            end
            GRANT: begin
                state_d = WAIT_FIN;
`ifdef EDABK_TX_ARB_TIMEOUT_EN
                wd_cnt_d = '0;
`endif
            end
            WAIT_FIN: begin
                if (tx_finish) begin
                    state_d = RELEASE;
                end
`ifdef EDABK_TX_ARB_TIMEOUT_EN
                else if (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d      = RELEASE;
                    tx_timeout_d = 1'b1;
                end else begin
                    wd_cnt_d = wd_cnt + 1'b1;
                end
`endif
            end
            RELEASE: begin
                state_d  = IDLE;
                rr_ptr_d = (grant_id == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_d = (state_d != IDLE);

    // State and registered outputs, synchronous reset
    always_ff @(posedge bclk) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            tx_data   <= '0;
            grant_id  <= '0;
            tx_start  <= 1'b0;
            req_ready <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            rr_ptr    <= rr_ptr_d;
            tx_data   <= tx_data_d;
            grant_id  <= grant_id_d;
            tx_start  <= tx_start_d;
            req_ready <= req_ready_d;
            busy      <= busy_d;
        end
    end

`ifdef EDABK_TX_ARB_TIMEOUT_EN
    // Watchdog counter and its abort pulse
    always_ff @(posedge bclk) begin
        if (reset) begin
            wd_cnt     <= '0;
            tx_timeout <= 1'b0;
        end else begin
            wd_cnt     <= wd_cnt_d;
            tx_timeout <= tx_timeout_d;
        end
    end
`endif

endmodule

// File: tb/tb_edabk_tx_arbiter.sv
// Directed self-checking bench for edabk_tx_arbiter (4 requesters) plus a
// 3-requester instance for non-power-of-two wrap.

`ifndef CFG_DATA_WIDTH
`define CFG_DATA_WIDTH 8
`endif

module tb_edabk_tx_arbiter;
    import edabk_tx_arb_pkg::*;

    localparam int DW = `CFG_DATA_WIDTH;

    logic          bclk = 1'b0;
    logic          reset = 1'b1;
    logic [3:0]    req_valid = '0;
    logic [4*DW-1:0] req_data = '0;
    logic [3:0]    req_ready;
    logic          tx_start;
    logic [DW-1:0] tx_data;
    logic          tx_finish = 1'b0;
    logic [1:0]    grant_id;
    logic          busy;
    logic          tx_timeout;

    logic [2:0]    req_valid3 = '0;
    logic [3*DW-1:0] req_data3 = '0;
    logic [2:0]    req_ready3;
    logic          tx_start3;
    logic [DW-1:0] tx_data3;
    logic          tx_finish3 = 1'b0;
    logic [1:0]    grant_id3;
    logic          busy3;
    logic          tx_timeout3;

    int checks = 0;
    int errors = 0;

    always #5 bclk = ~bclk;

    edabk_tx_arbiter #(.NUM_REQ(4), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)) dut (
        .bclk(bclk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data),
        .tx_finish(tx_finish), .grant_id(grant_id), .busy(busy), .tx_timeout(tx_timeout)
    );

    edabk_tx_arbiter #(.NUM_REQ(3), .DATA_WIDTH(DW)) dut3 (
        .bclk(bclk), .reset(reset), .req_valid(req_valid3), .req_data(req_data3),
        .req_ready(req_ready3), .tx_start(tx_start3), .tx_data(tx_data3),
        .tx_finish(tx_finish3), .grant_id(grant_id3), .busy(busy3), .tx_timeout(tx_timeout3)
    );

    task automatic tick();
        @(posedge bclk);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        req_valid  = '0;
        req_valid3 = '0;
        tx_finish  = 1'b0;
        tx_finish3 = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (tx_start !== 1'b0) begin errors++; $display("[TB] FAIL rst_tx_start got %0b exp 0", tx_start); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL rst_req_ready got %b exp 0000", req_ready); end
        checks++; if (tx_data !== '0) begin errors++; $display("[TB] FAIL rst_tx_data got %h exp 0", tx_data); end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("[TB] FAIL rst_grant_id got %0d exp 0", grant_id); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy got %0b exp 0", busy); end
        checks++; if (tx_timeout !== 1'b0) begin errors++; $display("[TB] FAIL rst_tx_timeout got %0b exp 0", tx_timeout); end
        checks++; if (dut.rr_ptr !== 2'd0) begin errors++; $display("[TB] FAIL rst_rr_ptr got %0d exp 0", dut.rr_ptr); end
    endtask

    task automatic test_single();
        do_reset();
        req_data  = {DW'(8'h44), DW'(8'hA5), DW'(8'h22), DW'(8'h11)};
        req_valid = 4'b0100;
        tick();
        checks++; if (tx_start !== 1'b1) begin errors++; $display("[TB] FAIL single_start got %0b exp 1", tx_start); end
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("[TB] FAIL single_ready got %b exp 0100", req_ready); end
        checks++; if (tx_data !== DW'(8'hA5)) begin errors++; $display("[TB] FAIL single_data got %h exp a5", tx_data); end
        checks++; if (grant_id !== 2'd2) begin errors++; $display("[TB] FAIL single_grant got %0d exp 2", grant_id); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy got %0b exp 1", busy); end
        req_valid = 4'b0000;
        tick();
        checks++; if (tx_start !== 1'b0 || req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL single_wait_pulses got start=%0b ready=%b exp 0/0000", tx_start, req_ready); end
        checks++; if (tx_data !== DW'(8'hA5) || grant_id !== 2'd2) begin errors++; $display("[TB] FAIL single_hold got data=%h grant=%0d exp a5/2", tx_data, grant_id); end
        tx_finish = 1'b1;
        tick();
        tx_finish = 1'b0;
        checks++; if (dut.state !== RELEASE || busy !== 1'b1) begin errors++; $display("[TB] FAIL single_release got state=%0d busy=%0b exp 3/1", dut.state, busy); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL single_idle_busy got %0b exp 0", busy); end
        checks++; if (dut.rr_ptr !== 2'd3) begin errors++; $display("[TB] FAIL single_rr_ptr got %0d exp 3", dut.rr_ptr); end
    endtask

    task automatic test_all_valid();
        int exp_id;
        int pulses;
        do_reset();
        req_data  = {DW'(8'hD3), DW'(8'hC2), DW'(8'hB1), DW'(8'hA0)};
        req_valid = 4'b1111;
        for (int f = 0; f < 5; f++) begin
            exp_id = f % 4;
            tick();
            pulses = $countones(req_ready);
            checks++; if (tx_start !== 1'b1 || grant_id !== 2'(exp_id)) begin errors++; $display("[TB] FAIL rr_grant_%0d got start=%0b id=%0d exp 1/%0d", f, tx_start, grant_id, exp_id); end
            checks++; if (req_ready !== (4'b0001 << exp_id)) begin errors++; $display("[TB] FAIL rr_ready_%0d got %b exp %b", f, req_ready, 4'b0001 << exp_id); end
            for (int c = 0; c < 9; c++) begin
                tick();
                pulses += $countones(req_ready);
            end
            tx_finish = 1'b1;
            tick();
            tx_finish = 1'b0;
            pulses += $countones(req_ready);
            tick();
            pulses += $countones(req_ready);
            checks++; if (pulses != 1) begin errors++; $display("[TB] FAIL rr_pulses_%0d got %0d exp 1", f, pulses); end
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_late_request();
        do_reset();
        req_data  = {DW'(8'h04), DW'(8'h03), DW'(8'h22), DW'(8'h11)};
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b0000;
        tick();
        req_valid = 4'b0010;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (req_ready !== 4'b0000 || tx_start !== 1'b0) begin errors++; $display("[TB] FAIL late_wait_%0d got ready=%b start=%0b exp 0000/0", c, req_ready, tx_start); end
        end
        tx_finish = 1'b1;
        tick();
        tx_finish = 1'b0;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL late_release got %b exp 0000", req_ready); end
        tick();
        checks++; if (req_ready !== 4'b0000 || busy !== 1'b0) begin errors++; $display("[TB] FAIL late_idle got ready=%b busy=%0b exp 0000/0", req_ready, busy); end
        tick();
        checks++; if (req_ready !== 4'b0010 || grant_id !== 2'd1 || tx_data !== DW'(8'h22)) begin errors++; $display("[TB] FAIL late_grant got ready=%b id=%0d data=%h exp 0010/1/22", req_ready, grant_id, tx_data); end
        req_valid = 4'b0000;
    endtask

    task automatic test_finish_ignored();
        do_reset();
        req_data  = {DW'(8'h5C), DW'(8'h00), DW'(8'h00), DW'(8'h00)};
        tx_finish = 1'b1;
        tick();
        checks++; if (busy !== 1'b0 || tx_start !== 1'b0) begin errors++; $display("[TB] FAIL fin_idle got busy=%0b start=%0b exp 0/0", busy, tx_start); end
        req_valid = 4'b1000;
        tick();
        req_valid = 4'b0000;
        checks++; if (tx_start !== 1'b1 || grant_id !== 2'd3) begin errors++; $display("[TB] FAIL fin_grant got start=%0b id=%0d exp 1/3", tx_start, grant_id); end
        tick();
        tx_finish = 1'b0;
        checks++; if (dut.state !== WAIT_FIN) begin errors++; $display("[TB] FAIL fin_coincident got state=%0d exp 2", dut.state); end
        tick();
        checks++; if (dut.state !== WAIT_FIN || busy !== 1'b1) begin errors++; $display("[TB] FAIL fin_still_wait got state=%0d busy=%0b exp 2/1", dut.state, busy); end
        tx_finish = 1'b1;
        tick();
        tx_finish = 1'b0;
        tick();
        checks++; if (dut.rr_ptr !== 2'd0) begin errors++; $display("[TB] FAIL fin_wrap_ptr got %0d exp 0", dut.rr_ptr); end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        req_data  = {DW'(8'h00), DW'(8'h77), DW'(8'h66), DW'(8'h00)};
        req_valid = 4'b0010;
        tick();
        req_valid = 4'b0000;
        tick();
        tx_finish = 1'b1;
        tick();
        tx_finish = 1'b0;
        tick();
        checks++; if (dut.rr_ptr !== 2'd2) begin errors++; $display("[TB] FAIL mid_pre_ptr got %0d exp 2", dut.rr_ptr); end
        req_valid = 4'b0100;
        tick();
        req_valid = 4'b0000;
        tick();
        reset = 1'b1;
        tick();
        checks++; if (tx_start !== 1'b0 || req_ready !== 4'b0000 || busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_outputs got start=%0b ready=%b busy=%0b exp 0/0000/0", tx_start, req_ready, busy); end
        checks++; if (tx_data !== '0 || grant_id !== 2'd0 || dut.rr_ptr !== 2'd0) begin errors++; $display("[TB] FAIL mid_regs got data=%h id=%0d ptr=%0d exp 0/0/0", tx_data, grant_id, dut.rr_ptr); end
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++; if (tx_start !== 1'b0 || req_ready !== 4'b0000 || busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_stray_%0d got start=%0b ready=%b busy=%0b exp 0/0000/0", c, tx_start, req_ready, busy); end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        req_data  = {DW'(8'h00), DW'(8'h00), DW'(8'h00), DW'(8'h3E)};
        req_valid = 4'b0001;
        tick();
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL b2b_first got %b exp 0001", req_ready); end
        tick();
        tx_finish = 1'b1;
        tick();
        tx_finish = 1'b0;
        tick();
        checks++; if (tx_start !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_gap got start=%0b busy=%0b exp 0/0", tx_start, busy); end
        tick();
        checks++; if (tx_start !== 1'b1 || req_ready !== 4'b0001 || grant_id !== 2'd0) begin errors++; $display("[TB] FAIL b2b_second got start=%0b ready=%b id=%0d exp 1/0001/0", tx_start, req_ready, grant_id); end
        req_valid = 4'b0000;
    endtask

    task automatic test_three_wrap();
        do_reset();
        req_data3  = {DW'(8'h33), DW'(8'h22), DW'(8'h11)};
        req_valid3 = 3'b111;
        for (int f = 0; f < 4; f++) begin
            tick();
            checks++; if (tx_start3 !== 1'b1 || grant_id3 !== 2'(f % 3)) begin errors++; $display("[TB] FAIL wrap3_grant_%0d got start=%0b id=%0d exp 1/%0d", f, tx_start3, grant_id3, f % 3); end
            tick();
            tx_finish3 = 1'b1;
            tick();
            tx_finish3 = 1'b0;
            tick();
        end
        req_valid3 = 3'b000;
    endtask

`ifdef EDABK_TX_ARB_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        req_data  = {DW'(8'h00), DW'(8'h00), DW'(8'h2B), DW'(8'h1A)};
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b0010;
        tick();
        for (int c = 0; c < 15; c++) begin
            tick();
            checks++; if (tx_timeout !== 1'b0) begin errors++; $display("[TB] FAIL to_early_%0d got %0b exp 0", c, tx_timeout); end
        end
        tick();
        checks++; if (tx_timeout !== 1'b1 || dut.state !== RELEASE) begin errors++; $display("[TB] FAIL to_pulse got to=%0b state=%0d exp 1/3", tx_timeout, dut.state); end
        tick();
        checks++; if (tx_timeout !== 1'b0) begin errors++; $display("[TB] FAIL to_single got %0b exp 0", tx_timeout); end
        tick();
        checks++; if (tx_start !== 1'b1 || grant_id !== 2'd1) begin errors++; $display("[TB] FAIL to_next_grant got start=%0b id=%0d exp 1/1", tx_start, grant_id); end
        req_valid = 4'b0000;
    endtask
`else
    task automatic test_timeout();
        do_reset();
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b0000;
        for (int c = 0; c < 24; c++) begin
            tick();
            checks++; if (tx_timeout !== 1'b0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL nto_%0d got to=%0b busy=%0b exp 0/1", c, tx_timeout, busy); end
        end
    endtask
`endif

    initial begin
        $display("[TB] starting edabk_tx_arbiter bench");
        test_reset();
        test_single();
        test_all_valid();
        test_late_request();
        test_finish_ignored();
        test_reset_midframe();
        test_back_to_back();
        test_three_wrap();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
